// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct decodes and FSM states.
package md_pkg;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;
endpackage

// File: rtl/md_step.sv
// One iteration on the {acc, q} working pair: a shift-add multiply step (q holds the
// multiplier, product shifts in from the top) or one restoring-divide step (q holds the dividend).
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] sum, addend, rem, diff;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, m_i};
    addend = q_i[0] ? sum : {1'b0, acc_i};
    rem    = {acc_i, q_i[WIDTH-1]};
    // acc < m always holds, so rem < 2m and diff's top bit is a clean borrow flag
    diff   = rem - {1'b0, m_i};
    if (is_div) begin
      acc_o = diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_o = addend[WIDTH:1];
      q_o   = {addend[0], q_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO. Operands are made unsigned on entry,
// iterated WIDTH times through md_step, and sign-corrected in FIX.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);
  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dzp_q, dzp_d;
  logic             done_q, done_d, dz_q, dz_d, ill_q, ill_d;

  logic [WIDTH-1:0]   step_acc, step_q, a_abs, b_abs;
  logic [2*WIDTH-1:0] prod;
  logic               sgn, a_neg, b_neg;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_comb begin
    sgn   = ~funct[0];
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
    prod  = neg_q ? -{acc_q, q_q} : {acc_q, q_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dzp_d   = dzp_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    ill_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start) begin
        unique case (funct)
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            div_d = funct[1];
            if (funct[1] && b == '0) begin
              // divide by zero skips iteration; FIX writes hi=a, lo=all ones
              acc_d   = a;
              q_d     = '1;
              dzp_d   = 1'b1;
              state_d = ST_FIX;
            end else begin
              acc_d   = '0;
              q_d     = funct[1] ? a_abs : b_abs;
              m_d     = funct[1] ? b_abs : a_abs;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dzp_d   = 1'b0;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = ST_ITER;
            end
          end
          FN_MTHI: hi_d = a;
          FN_MTLO: lo_d = a;
          FN_MFHI, FN_MFLO: ;
          default: ill_d = 1'b1;
        endcase
      end
      ST_ITER: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dzp_q) begin
          hi_d = acc_q;
          lo_d = q_q;
          dz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rneg_q ? -acc_q : acc_q;
          lo_d = neg_q ? -q_q : q_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dzp_q   <= dzp_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign dz      = dz_q;
  assign illegal = ill_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = (funct == FN_MFLO) ? lo_q : hi_q;
endmodule
